// File: rtl/bsg_pkg.sv
// Shared types and constants for the BSG serial transmit engine.
package bsg_pkg;

  localparam int BSG_DATA_W   = 8;
  localparam int BSG_STATUS_W = 5;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_BYTE_SEL = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } bsg_tx_state_t;

endpackage

// File: rtl/bsg_tx_if.sv
// Register-block side of the transmit engine: control, data bytes, status and line outputs.
interface bsg_tx_if;
  import bsg_pkg::*;

  logic                    tx_enable;
  logic                    int_mask;
  logic [BSG_DATA_W-1:0]   data1;
  logic [BSG_DATA_W-1:0]   data2;
  logic [BSG_STATUS_W-1:0] status;
  logic                    tx_out;
  logic                    irq;

  modport master (
    output tx_enable, int_mask, data1, data2,
    input  status, tx_out, irq
  );

  modport slave (
    input  tx_enable, int_mask, data1, data2,
    output status, tx_out, irq
  );

endinterface

// File: rtl/bsg_baud_tick.sv
// Bit-period divider: counts 0..DIV-1 and ticks on the last count; restart forces 0.
module bsg_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 8'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart_i || tick_o) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bsg_tx.sv
// BSG transmit engine: sends data1 then data2 as two start/8-data/stop frames.
module bsg_tx
  import bsg_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int DATA_W = BSG_DATA_W
) (
  input logic     clk,
  input logic     rst,
  bsg_tx_if.slave bus
);

  bsg_tx_state_t         state_q, state_d;
  logic [2*DATA_W-1:0]   shadow_q, shadow_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic                  byte_sel_q, byte_sel_d;
  logic                  done_q, done_d;
  logic                  done_pulse_q, done_pulse_d;
  logic                  en_q;
  logic                  tick;
  logic                  start;
  logic                  line_bit;
  logic [BSG_STATUS_W-1:0] status_w;

  // Divider restarts whenever the FSM changes state, so every state gets full bit periods.
  bsg_baud_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (state_d != state_q),
    .tick_o    (tick)
  );

  assign start = (state_q == IDLE) && bus.tx_enable && !en_q;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    bit_idx_d    = bit_idx_q;
    byte_sel_d   = byte_sel_q;
    done_d       = done_q;
    done_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d   = {bus.data2, bus.data1};
          done_d     = 1'b0;
          byte_sel_d = 1'b0;
          bit_idx_d  = 3'd0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = START;
          end else begin
            state_d      = IDLE;
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping TXENABLE mid-transfer abandons it without completing or interrupting.
    if (state_q != IDLE && !bus.tx_enable) begin
      state_d      = IDLE;
      byte_sel_d   = byte_sel_q;
      done_d       = done_q;
      done_pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      bit_idx_q    <= 3'd0;
      byte_sel_q   <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      bit_idx_q    <= bit_idx_d;
      byte_sel_q   <= byte_sel_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      en_q         <= bus.tx_enable;
    end
  end

  always_comb begin
    line_bit = 1'b1;
    case (state_q)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shadow_q[{byte_sel_q, bit_idx_q}];
      default: line_bit = 1'b1;
    endcase
  end

  always_comb begin
    status_w              = '0;
    status_w[ST_BUSY]     = (state_q != IDLE);
    status_w[ST_DONE]     = done_q;
    status_w[ST_BYTE_SEL] = byte_sel_q;
  end

  assign bus.tx_out = line_bit;
  assign bus.status = status_w;
  assign bus.irq    = done_pulse_q & bus.int_mask;

endmodule

// File: tb/tb_bsg_tx.sv
// Directed bench for bsg_tx: frame waveforms, done/irq, abort, retrigger, shadow and async reset.
module tb_bsg_tx;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   clkRun = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  bsg_tx_if bus ();

  bsg_tx #(.DIV(DIV), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock can be frozen low to show that reset does not need an edge.
  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic mask, input logic [7:0] d1, input logic [7:0] d2);
    bus.tx_enable = en;
    bus.int_mask  = mask;
    bus.data1     = d1;
    bus.data2     = d2;
  endtask

  // Expected line level per bit period: start, 8 data bits LSB first, stop; twice.
  function automatic logic [19:0] buildLine(input logic [7:0] d1, input logic [7:0] d2);
    logic [19:0] l;
    l[0]  = 1'b0;
    l[9]  = 1'b1;
    l[10] = 1'b0;
    l[19] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      l[1 + i]  = d1[i];
      l[11 + i] = d2[i];
    end
    return l;
  endfunction

  task automatic runTransfer(input logic [7:0] d1, input logic [7:0] d2, input logic mask,
                             input int abortAt, input int shadowAt);
    logic [19:0] line;
    line = buildLine(d1, d2);
    applyStimulus(1'b1, mask, d1, d2);
    for (int k = 0; k < 20 * DIV; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tx_out k=%0d", k), bus.tx_out, line[k / DIV]);
      checkOutput($sformatf("busy k=%0d", k), bus.status[0], 1'b1);
      checkOutput($sformatf("done k=%0d", k), bus.status[1], 1'b0);
      checkOutput($sformatf("byte_sel k=%0d", k), bus.status[2], (k >= 10 * DIV));
      checkOutput($sformatf("irq k=%0d", k), bus.irq, 1'b0);
      if (k == shadowAt) bus.data1 = 8'hFF;
      if (k == abortAt) begin
        bus.tx_enable = 1'b0;
        @(negedge clk);
        checkOutput("abort tx_out", bus.tx_out, 1'b1);
        checkOutput("abort status", bus.status, 5'b00000);
        checkOutput("abort irq", bus.irq, 1'b0);
        repeat (3) begin
          @(negedge clk);
          checkOutput("abort no irq", bus.irq, 1'b0);
          checkOutput("abort stays idle", bus.tx_out, 1'b1);
        end
        return;
      end
    end
    @(negedge clk);
    checkOutput("end tx_out", bus.tx_out, 1'b1);
    checkOutput("end status", bus.status, 5'b00110);
    checkOutput("end irq", bus.irq, mask);
    @(negedge clk);
    checkOutput("post irq", bus.irq, 1'b0);
    checkOutput("post status", bus.status, 5'b00110);
  endtask

  task automatic dropEnable();
    bus.tx_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset tx_out", bus.tx_out, 1'b1);
    checkOutput("reset status", bus.status, 5'b00000);
    checkOutput("reset irq", bus.irq, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle tx_out", bus.tx_out, 1'b1);

    $display("[TB] normal transfer, int_mask=1");
    runTransfer(8'hA5, 8'h3C, 1'b1, -1, -1);

    $display("[TB] level hold does not retrigger");
    repeat (20) @(negedge clk);
    checkOutput("hold busy", bus.status[0], 1'b0);
    checkOutput("hold tx_out", bus.tx_out, 1'b1);
    checkOutput("hold done", bus.status[1], 1'b1);

    $display("[TB] toggle and transfer with int_mask=0");
    dropEnable();
    runTransfer(8'hA5, 8'h3C, 1'b0, -1, -1);

    $display("[TB] shadow copy ignores data1 change");
    dropEnable();
    runTransfer(8'hA5, 8'h3C, 1'b1, -1, 5);
    checkOutput("data1 changed", bus.data1, 8'hFF);

    $display("[TB] abort then restart");
    dropEnable();
    runTransfer(8'hA5, 8'h3C, 1'b1, 29, -1);
    runTransfer(8'hA5, 8'h3C, 1'b1, -1, -1);

    $display("[TB] edge-value data bytes");
    dropEnable();
    runTransfer(8'h01, 8'h80, 1'b1, -1, -1);

    $display("[TB] async reset with clock stopped");
    dropEnable();
    applyStimulus(1'b1, 1'b1, 8'hA5, 8'h3C);
    repeat (3) @(negedge clk);
    checkOutput("pre-reset busy", bus.status[0], 1'b1);
    checkOutput("pre-reset tx_out", bus.tx_out, 1'b0);
    clkRun = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async tx_out", bus.tx_out, 1'b1);
    checkOutput("async status", bus.status, 5'b00000);
    checkOutput("async irq", bus.irq, 1'b0);
    bus.tx_enable = 1'b0;
    #2;
    rst = 1'b0;
    clkRun = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    checkOutput("after reset idle", bus.status, 5'b00000);
    checkOutput("after reset tx_out", bus.tx_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bsg_tx.md
# bsg_tx

Serial transmit engine of the BSG peripheral, sitting directly downstream of the AMBA register block. It consumes TXENABLE/INTMSK and the two data bytes held in the register block, serialises data1 then data2 as two UART-style frames on a single output line, and returns the read-only status field that the register block maps into BSG_CONTROL[7:3]. STATUS (busy) from this block is what gates new register writes and raises INT_FLAG upstream.

## Interface
- DIV, 4: clock cycles per bit period; legal range 2..255.
- DATA_W, 8: byte width; fixed at 8 for this peripheral.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- tx_enable  in  1  BSG_CONTROL[0] (TXENABLE) from the register block.
- int_mask  in  1  BSG_CONTROL[1] (INTMSK).
- data1  in  8  first byte to send.
- data2  in  8  second byte to send.
- status  out  5  to BSG_CONTROL[7:3]: [0] STATUS busy, [1] DONE sticky, [2] BYTE_SEL (0 = data1 frame, 1 = data2 frame), [4:3] reserved, always 0.
- tx_out  out  1  serial line, idle high.
- irq  out  1  one-cycle interrupt pulse.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- tx_enable is registered once (en_q); start condition = tx_enable & ~en_q while in IDLE (rising edge only; a level held high does not retrigger).
- On start: latch data1/data2 into a 16-bit shadow register, clear DONE, set busy, BYTE_SEL=0, enter START.
- START: tx_out=0 for one bit period -> DATA.
- DATA: 8 bits LSB first, one bit period each, bit index 0..7 -> STOP after index 7.
- STOP: tx_out=1 for one bit period; if BYTE_SEL=0 -> BYTE_SEL=1, START; else -> IDLE, busy=0, DONE=1, done pulse.
- irq = done pulse & int_mask (combinational AND of a registered pulse).
- Abort: tx_enable low while busy -> next cycle IDLE, tx_out=1, busy=0, DONE unchanged (stays 0), no irq.
- data1/data2 changes during a transfer have no effect (shadow copy).
- A start edge arriving while busy is ignored.

## Timing
- Reset values: tx_out=1, status=5'b00000, irq=0, state IDLE, en_q=0, bit counter 0, shadow 0.
- tx_enable rises before edge N: en_q and the start decision are both taken at edge N; busy=1 and tx_out=0 visible after edge N.
- Each bit period lasts exactly DIV cycles; divider restarts at 0 on every state entry.
- Frame = 10*DIV cycles; full transfer = 20*DIV cycles from start edge to busy fall; no gap cycle between frames.
- Busy falls, DONE sets and irq pulses (if int_mask=1) on the same edge, 20*DIV cycles after edge N.
- int_mask sampled in the done cycle only.
- rst asserted mid-transfer: all outputs return to reset values immediately (asynchronously); no partial resumption.

## Structure
- Package bsg_pkg: FSM state enum (bsg_tx_state_t), status bit index constants (ST_BUSY=0, ST_DONE=1, ST_BYTE_SEL=2), BSG_DATA_W=8.
- Sub-module bsg_baud_tick: DIV-cycle counter with synchronous restart input, emits one-cycle tick at count DIV-1.
- Top holds FSM, shadow register, bit index (3 bits), BYTE_SEL, DONE, en_q.

## Test plan
- Reset: assert rst mid-cycle with clk stopped -> tx_out=1, status=0, irq=0 without a clock edge.
- Normal transfer, DIV=4, data1=0xA5, data2=0x3C, int_mask=1: tx_out = 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1 each bit 4 cycles; busy high 80 cycles; DONE=1 and one irq pulse at busy fall.
- int_mask=0, same data: identical waveform, DONE=1, irq never asserts.
- Abort: drop tx_enable at cycle 30 of transfer -> next cycle tx_out=1, busy=0, DONE=0, no irq; re-raise tx_enable -> fresh transfer starts from data1 start bit.
- Level hold/retrigger: keep tx_enable high after done -> no second transfer; toggle low then high -> second transfer; start edge while busy ignored.
- Shadow: change data1 to 0xFF at cycle 5 of transfer -> first frame still sends 0xA5.
